// File: rtl/trws_sweep_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trws_sweep_scheduler_pkg
// Description : Shared FSM states, pass-direction codes and passer latency
//               for the TRW-S sweep scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package trws_sweep_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FWD        = 3'd1,
        S_BWD        = 3'd2,
        S_PASS_DRAIN = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic c_dir_fwd = 1'b0;
    localparam logic c_dir_bwd = 1'b1;

    // Cycles from a push until the message passer returns its result.
    localparam int c_passer_latency = 8;

endpackage
`default_nettype wire

// File: rtl/trws_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trws_addr_fifo
// Description : Synchronous FIFO holding {address, direction} of requests
//               in flight in the message passer; combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module trws_addr_fifo #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int               c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_push = i_push && (r_count != c_full_count);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_full_count);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/trws_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : trws_sweep_scheduler
// Description : Issues pixel addresses in alternating forward/backward
//               raster sweeps and matches returning passer results to them.
// Revision    : 1.0 - initial release
// ============================================================================
module trws_sweep_scheduler
    import trws_sweep_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int ITER_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  width_px,
    input  logic [DIM_WIDTH-1:0]  height_px,
    input  logic [ITER_WIDTH-1:0] iterations,
    input  logic                  strict_hazard,
    input  logic                  stall,
    output logic                  push,
    output logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  issue_dir,
    input  logic                  passer_valid,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ITER_WIDTH-1:0] iter_count
);

    localparam int c_prod_w = 2 * DIM_WIDTH;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_total;
    logic                  r_dir;
    logic                  r_strict;
    logic                  r_error;
    logic [ITER_WIDTH-1:0] r_iterations;
    logic [ITER_WIDTH-1:0] r_iter_count;

    logic [c_prod_w-1:0]   w_product;
    logic                  w_start_accept;
    logic                  w_zero_run;
    logic                  w_issue_state;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_issue;
    logic                  w_drained;
    logic                  w_last_iter;
    logic                  w_full;
    logic                  w_empty;
    logic [c_cnt_w-1:0]    w_count;

    // Only multiply once per run; addresses then come from the counter.
    assign w_product      = {{DIM_WIDTH{1'b0}}, width_px} * {{DIM_WIDTH{1'b0}}, height_px};
    assign w_start_accept = start && (r_state == S_IDLE);
    assign w_zero_run     = (w_product == '0) || (iterations == '0);
    assign w_issue_state  = (r_state == S_FWD) || (r_state == S_BWD);
    assign w_push         = w_issue_state && !stall && !w_full && (!r_strict || (w_count == '0));
    assign w_pop          = passer_valid && !w_empty;
    assign w_last_issue   = (r_state == S_FWD) ? (r_addr == r_total - ADDR_WIDTH'(1))
                                               : (r_addr == '0);
    assign w_drained      = (w_count == '0);
    assign w_last_iter    = ((r_iter_count + ITER_WIDTH'(1)) == r_iterations);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (start) w_next_state = w_zero_run ? S_DONE : S_FWD;
            S_FWD,
            S_BWD:        if (w_push && w_last_issue) w_next_state = S_PASS_DRAIN;
            S_PASS_DRAIN: if (w_drained) begin
                              if (r_dir == c_dir_fwd) w_next_state = S_BWD;
                              else                    w_next_state = w_last_iter ? S_DONE : S_FWD;
                          end
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_total      <= '0;
            r_dir        <= c_dir_fwd;
            r_strict     <= 1'b0;
            r_iterations <= '0;
            r_iter_count <= '0;
            r_error      <= 1'b0;
        end else begin
            r_error <= (r_error && !w_start_accept) || (passer_valid && w_empty);
            if (w_start_accept) begin
                r_total      <= ADDR_WIDTH'(w_product);
                r_iterations <= iterations;
                r_strict     <= strict_hazard;
                r_addr       <= '0;
                r_dir        <= c_dir_fwd;
                r_iter_count <= '0;
            end else begin
                case (r_state)
                    S_FWD: if (w_push && !w_last_issue) r_addr <= r_addr + ADDR_WIDTH'(1);
                    S_BWD: if (w_push && !w_last_issue) r_addr <= r_addr - ADDR_WIDTH'(1);
                    S_PASS_DRAIN: if (w_drained) begin
                        if (r_dir == c_dir_fwd) begin
                            r_dir  <= c_dir_bwd;
                            r_addr <= r_total - ADDR_WIDTH'(1);
                        end else begin
                            r_dir        <= c_dir_fwd;
                            r_addr       <= '0;
                            r_iter_count <= r_iter_count + ITER_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    trws_addr_fifo #(
        .DATA_WIDTH (ADDR_WIDTH + 1),
        .DEPTH      (FIFO_DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_addr, r_dir}),
        .o_rdata ({wb_addr, wb_dir}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign push       = w_push;
    assign issue_addr = r_addr;
    assign issue_dir  = r_dir;
    assign wb_en      = w_pop;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign error      = r_error;
    assign iter_count = r_iter_count;

endmodule
`default_nettype wire
